// File: rtl/bayer_gray_downsample.sv
// Bayer 2x2 block to 12-bit grayscale downsampler, one output pixel per G1 R / B G2 block.
// Latency 1 from the completing odd-column beat; no backpressure. Optional GRAY_LUMA_EN selects luma weighting.
module bayer_gray_downsample #(
    parameter int ROW_WIDTH = 1280,
    parameter int ROW_COUNT = 960
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic [11:0] iTap0,
    input  logic [11:0] iTap1,
    output logic [11:0] oGRAY,
    output logic        oDVAL,
    output logic [9:0]  oX,
    output logic [9:0]  oY
);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_ACTIVE = 1'b1;
    localparam logic [10:0] COL_LAST = 11'(ROW_WIDTH - 1);
    localparam logic [10:0] ROW_MAX  = 11'(ROW_COUNT);

    logic [0:0]  state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic [11:0] g1_q, g1_d;
    logic [11:0] b_q, b_d;
    logic [11:0] gray_q, gray_d;
    logic        dval_q, dval_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;

    logic        assemble;
    logic [11:0] gray_calc;

    // Only odd rows carry both halves of a block: iTap1 holds the G1/R row above.
    assign assemble = row_q[0] && (row_q < ROW_MAX);

`ifdef GRAY_LUMA_EN
    logic [15:0] luma_sum;
    assign luma_sum  = 16'd5 * {4'd0, iTap1} + 16'd5 * {4'd0, g1_q}
                     + 16'd5 * {4'd0, iTap0} + {4'd0, b_q};
    assign gray_calc = 12'(luma_sum >> 4);
`else
    logic [13:0] avg_sum;
    assign avg_sum   = {2'd0, g1_q} + {2'd0, iTap1} + {2'd0, b_q} + {2'd0, iTap0};
    assign gray_calc = 12'(avg_sum >> 2);
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        g1_d    = g1_q;
        b_d     = b_q;
        gray_d  = gray_q;
        x_d     = x_q;
        y_d     = y_q;
        dval_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                col_d = '0;
                row_d = '0;
                if (iFVAL) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!iFVAL) begin
                    // Frame drop discards any half-assembled block.
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                    g1_d    = '0;
                    b_d     = '0;
                end else if (iDVAL) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q != ROW_MAX) begin
                            row_d = row_q + 11'd1;
                        end
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                    if (assemble) begin
                        if (!col_q[0]) begin
                            g1_d = iTap1;
                            b_d  = iTap0;
                        end else begin
                            gray_d = gray_calc;
                            x_d    = col_q[10:1];
                            y_d    = row_q[10:1];
                            dval_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            g1_q    <= '0;
            b_q     <= '0;
            gray_q  <= '0;
            dval_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            g1_q    <= g1_d;
            b_q     <= b_d;
            gray_q  <= gray_d;
            dval_q  <= dval_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign oGRAY = gray_q;
    assign oDVAL = dval_q;
    assign oX    = x_q;
    assign oY    = y_q;

endmodule

// File: tb/tb_bayer_gray_downsample.sv
// Directed bench for bayer_gray_downsample on a small 8x4 Bayer frame.
module tb_bayer_gray_downsample;

    localparam int RW = 8;
    localparam int RC = 4;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFVAL;
    logic        iDVAL;
    logic [11:0] iTap0;
    logic [11:0] iTap1;
    logic [11:0] oGRAY;
    logic        oDVAL;
    logic [9:0]  oX;
    logic [9:0]  oY;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    bayer_gray_downsample #(.ROW_WIDTH(RW), .ROW_COUNT(RC)) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iFVAL (iFVAL),
        .iDVAL (iDVAL),
        .iTap0 (iTap0),
        .iTap1 (iTap1),
        .oGRAY (oGRAY),
        .oDVAL (oDVAL),
        .oX    (oX),
        .oY    (oY)
    );

    always #5 iCLK = ~iCLK;

`ifdef GRAY_LUMA_EN
    localparam logic [11:0] EXP_BLOCK = 12'd238;
    localparam logic [11:0] EXP_MIXED = 12'd1536;
`else
    localparam logic [11:0] EXP_BLOCK = 12'd251;
    localparam logic [11:0] EXP_MIXED = 12'd2048;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs applied; outputs sampled 1 ns after the edge.
    task automatic step(input logic dv, input logic [11:0] t1, input logic [11:0] t0);
        iDVAL = dv;
        iTap1 = t1;
        iTap0 = t0;
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        if (oDVAL === 1'b1) pulses++;
    endtask

    // A full row of identical beats; out_y < 0 means the row must produce nothing.
    task automatic do_row(input logic [11:0] t1, input logic [11:0] t0, input int out_y,
                          input logic [11:0] exp_gray, input int gap);
        for (int c = 0; c < RW; c++) begin
            step(1'b1, t1, t0);
            if (out_y >= 0 && (c % 2) == 1) begin
                chk("row_dval", 32'(oDVAL), 32'd1);
                chk("row_gray", 32'(oGRAY), 32'(exp_gray));
                chk("row_x", 32'(oX), 32'(c / 2));
                chk("row_y", 32'(oY), 32'(out_y));
            end else begin
                chk("row_no_dval", 32'(oDVAL), 32'd0);
            end
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 12'd0, 12'd0);
                chk("gap_no_dval", 32'(oDVAL), 32'd0);
            end
        end
    endtask

    initial begin
        iRST  = 1'b0;
        iFVAL = 1'b0;
        iDVAL = 1'b0;
        iTap0 = '0;
        iTap1 = '0;
        #1;
        step(1'b0, 12'd0, 12'd0);
        chk("rst_gray", 32'(oGRAY), 32'd0);
        chk("rst_dval", 32'(oDVAL), 32'd0);
        chk("rst_x", 32'(oX), 32'd0);
        chk("rst_y", 32'(oY), 32'd0);
        iRST = 1'b1;
        step(1'b0, 12'd0, 12'd0);

        // Uniform frame: 4 pulses per odd row, 8 total.
        iFVAL = 1'b1;
        step(1'b0, 12'd0, 12'd0);
        pulses = 0;
        do_row(12'h800, 12'h800, -1, 12'h000, 0);
        do_row(12'h800, 12'h800,  0, 12'h800, 0);
        do_row(12'h800, 12'h800, -1, 12'h000, 0);
        do_row(12'h800, 12'h800,  1, 12'h800, 0);
        chk("uniform_pulses", 32'(pulses), 32'd8);
        // Rows beyond the frame end are counted but silent.
        do_row(12'hFFF, 12'hFFF, -1, 12'h000, 0);
        do_row(12'hFFF, 12'hFFF, -1, 12'h000, 0);
        chk("extra_rows_pulses", 32'(pulses), 32'd8);
        chk("extra_rows_gray_held", 32'(oGRAY), 32'h800);
        iFVAL = 1'b0;
        step(1'b0, 12'd0, 12'd0);

        // Distinct block with a stall, then a mid-row frame drop.
        iFVAL = 1'b1;
        step(1'b0, 12'd0, 12'd0);
        do_row(12'd0, 12'd0, -1, 12'd0, 0);
        step(1'b1, 12'd100, 12'd300);
        chk("blk_even_no_dval", 32'(oDVAL), 32'd0);
        for (int g = 0; g < 3; g++) step(1'b0, 12'd0, 12'd0);
        step(1'b1, 12'd200, 12'd404);
        chk("blk_dval", 32'(oDVAL), 32'd1);
        chk("blk_gray", 32'(oGRAY), 32'(EXP_BLOCK));
        chk("blk_x", 32'(oX), 32'd0);
        chk("blk_y", 32'(oY), 32'd0);
        step(1'b0, 12'd0, 12'd0);
        chk("blk_pulse_one_cycle", 32'(oDVAL), 32'd0);
        chk("blk_gray_held", 32'(oGRAY), 32'(EXP_BLOCK));
        step(1'b1, 12'hFFF, 12'hFFF);
        iFVAL = 1'b0;
        pulses = 0;
        step(1'b1, 12'hFFF, 12'hFFF);
        step(1'b0, 12'd0, 12'd0);
        step(1'b0, 12'd0, 12'd0);
        chk("drop_no_pulse", 32'(pulses), 32'd0);
        chk("drop_gray_held", 32'(oGRAY), 32'(EXP_BLOCK));

        // Next frame restarts at (0,0); saturated taps with 3-cycle gaps.
        iFVAL = 1'b1;
        step(1'b0, 12'd0, 12'd0);
        do_row(12'd0, 12'd0, -1, 12'd0, 0);
        do_row(12'hFFF, 12'hFFF, 0, 12'hFFF, 3);
        do_row(12'd0, 12'd0, -1, 12'd0, 0);
        step(1'b1, 12'hFFF, 12'hFFF);
        step(1'b1, 12'd1, 12'd1);
        chk("mix_dval", 32'(oDVAL), 32'd1);
        chk("mix_gray", 32'(oGRAY), 32'(EXP_MIXED));
        chk("mix_y", 32'(oY), 32'd1);

        // Asynchronous reset while the output pulse is high.
        #2;
        iRST = 1'b0;
        #1;
        chk("arst_gray", 32'(oGRAY), 32'd0);
        chk("arst_dval", 32'(oDVAL), 32'd0);
        chk("arst_x", 32'(oX), 32'd0);
        chk("arst_y", 32'(oY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayer_gray_downsample.md
Name: bayer_gray_downsample

Overview:
- Consumes the two aligned taps of the Bayer pixel row buffer: current row and previous row, same column.
- Assembles each 2x2 Bayer block (G1 R / B G2) and emits one 12-bit grayscale pixel per block.
- Output grid is ROW_WIDTH/2 x ROW_COUNT/2 (640x480 default).
- Sits between the Bayer pixel row buffers and the grayscale row buffers feeding the 3x3 convolution.

Parameters:
- ROW_WIDTH, 1280, valid Bayer beats per camera row; must be even.
- ROW_COUNT, 960, Bayer rows per frame; must be even.

Ports:
- iCLK  input  1  D5M pixel clock.
- iRST  input  1  reset, asynchronous, active-low.
- iFVAL  input  1  frame valid; low clears position counters.
- iDVAL  input  1  taps valid this cycle. The caller delays it one clock so it is aligned with the registered taps.
- iTap0  input  12  current-row pixel.
- iTap1  input  12  previous-row pixel, same column.
- oGRAY  output  12  grayscale pixel.
- oDVAL  output  1  oGRAY/oX/oY valid, one-cycle pulse.
- oX  output  10  output column, 0..ROW_WIDTH/2-1.
- oY  output  10  output row, 0..ROW_COUNT/2-1.

Behaviour:
- Reset (iRST low, async): all outputs 0, counters 0, held pixels 0, FSM=IDLE.
- Counters:
  - col_cnt 0..ROW_WIDTH-1 advances on each iDVAL beat; wraps to 0 after ROW_WIDTH-1.
  - On wrap, row_cnt increments, saturating at ROW_COUNT.
- FSM (state changes only on iCLK):
  - IDLE: iFVAL low; counters held at 0. Go to ACTIVE on the first cycle iFVAL=1.
  - ACTIVE: accept beats. Go to IDLE whenever iFVAL=0; counters clear on that transition.
  - A mid-row drop of iFVAL discards any half-assembled block; no output is produced for it.
- Bayer mapping: even row = G1 R, odd row = B G2. In an odd row, iTap1 = G1/R (even row) and iTap0 = B/G2.
- Block assembly: only in odd rows (row_cnt[0]=1) with row_cnt < ROW_COUNT.
  - Even col beat: hold G1=iTap1 and B=iTap0.
  - Odd col beat: R=iTap1, G2=iTap0. Compute the result and register it.
- Even rows and row 0 produce no output. row 0's iTap1 contains stale previous-frame data and is never used.
- Arithmetic (default):
  - sum = G1+R+B+G2 in 14 bits.
  - oGRAY = sum[13:2], truncating.
- Output timing:
  - oDVAL=1 in the cycle after the odd-column beat, i.e. latency 1 from the completing beat.
  - oX = col_cnt>>1 and oY = row_cnt>>1, both captured with the beat.
  - oDVAL=0 in every other cycle. oGRAY/oX/oY hold their last value while oDVAL=0.
- Gaps: iDVAL low between beats stalls assembly; held G1/B are kept indefinitely.
- Beats after row_cnt reaches ROW_COUNT are counted but produce no output.
- iFVAL low overrides iDVAL in the same cycle: the beat is ignored.

Optional Feature:
- GRAY_LUMA_EN defined: luminance-weighted output.
  - sum = 5*R + 5*G1 + 5*G2 + B in 16 bits (max 65520, no overflow).
  - oGRAY = sum[15:4], i.e. weights 0.3125 R, 0.625 G, 0.0625 B.
  - Latency and timing are unchanged.
- GRAY_LUMA_EN undefined: the equal-weight average above.

Test Plan:
- Reset mid-frame: assert iRST low while oDVAL=1 -> oGRAY=0, oDVAL=0, oX=oY=0 immediately, without waiting for a clock.
- Uniform frame, all taps 12'h800, ROW_WIDTH=8, ROW_COUNT=4 -> exactly 8 oDVAL pulses, each oGRAY=12'h800. oX cycles 0..3 and oY takes 0 then 1.
- Distinct block, odd row: beat0 iTap1=100, iTap0=300; beat1 iTap1=200, iTap0=404 -> next cycle oGRAY=251 (1004>>2), oX=0. With GRAY_LUMA_EN: oGRAY=(500+1000+2020+300)>>4=238.
- Stalled beats: iDVAL gaps of 3 cycles between beats -> identical oGRAY values. oDVAL occurs exactly 1 cycle after each odd-column beat.
- iFVAL drop after an even-column beat in an odd row -> no oDVAL. The next frame's first output is oX=0, oY=0.
- Saturation: 4095 on all taps -> oGRAY=4095 in both modes. Extra rows beyond ROW_COUNT -> no oDVAL.
